// File: rtl/pulse_pkg.sv
// pulse_pkg: shared widths, scheduler state and configuration structs.
package pulse_pkg;
   localparam int TIME_W  = 32;
   localparam int CP_W    = 8;
   localparam int BL_W    = 8;
   localparam int BLOFF_W = 16;
   localparam int SWEEP_W = 16;

   typedef enum logic {IDLE, RUN} state_t;

   typedef struct packed {
      logic [TIME_W-1:0]  per;
      logic [TIME_W-1:0]  p1wid;
      logic [TIME_W-1:0]  del;
      logic [TIME_W-1:0]  p2wid;
      logic [CP_W-1:0]    cp;
      logic [BL_W-1:0]    p_bl;
      logic [BLOFF_W-1:0] p_bl_off;
      logic               bl;
      logic               pu;
   } pulse_cfg_t;

   typedef struct packed {
      logic [TIME_W-1:0]  inc;
      logic [SWEEP_W-1:0] n;
      logic [SWEEP_W-1:0] avg;
   } sweep_cfg_t;
endpackage

// File: rtl/period_timer.sv
// period_timer: master period counter with MIN_PERIOD clamp, boundary and cycle_start.
module period_timer #(
   parameter int               CNT_W      = 32,
   parameter logic [CNT_W-1:0] MIN_PERIOD = 64
) (
   input  logic             clk_pll,
   input  logic             resetn,
   input  logic             run,
   input  logic             restart,
   input  logic [CNT_W-1:0] period,
   output logic             boundary,
   output logic             cycle_start
);
   logic [CNT_W-1:0] cnt, eff_per;

   assign eff_per  = (period < MIN_PERIOD) ? MIN_PERIOD : period;
   assign boundary = run && (cnt == eff_per - 1'b1);

   always_ff @(posedge clk_pll) begin
      if (!resetn) begin
         cnt         <= '0;
         cycle_start <= 1'b0;
      end else if (restart) begin
         cnt         <= '0;
         cycle_start <= 1'b1;
      end else begin
         cnt         <= (run && !boundary) ? cnt + 1'b1 : '0;
         cycle_start <= boundary;
      end
   end
endmodule

// File: rtl/pulse_param_scheduler.sv
// pulse_param_scheduler: atomic period-boundary application of pulse parameters.
// Define PULSE_DELAY_SWEEP_EN to sweep the delay across periods.
module pulse_param_scheduler
   import pulse_pkg::*;
#(
   parameter logic [31:0] MIN_PERIOD = 32'd64,
   parameter int          CNT_W      = 32
) (
   input  logic                clk_pll,
   input  logic                resetn,
   input  logic                cfg_stb,
   input  logic [TIME_W-1:0]   cfg_per,
   input  logic [TIME_W-1:0]   cfg_p1wid,
   input  logic [TIME_W-1:0]   cfg_del,
   input  logic [TIME_W-1:0]   cfg_p2wid,
   input  logic [CP_W-1:0]     cfg_cp,
   input  logic [BL_W-1:0]     cfg_p_bl,
   input  logic [BLOFF_W-1:0]  cfg_p_bl_off,
   input  logic                cfg_bl,
   input  logic                cfg_pu,
   input  logic [TIME_W-1:0]   sweep_step,
   input  logic [SWEEP_W-1:0]  sweep_n,
   input  logic [SWEEP_W-1:0]  sweep_avg,
   output logic                cfg_busy,
   output logic [TIME_W-1:0]   period,
   output logic [TIME_W-1:0]   p1width,
   output logic [TIME_W-1:0]   delay,
   output logic [TIME_W-1:0]   p2width,
   output logic [CP_W-1:0]     cpmg,
   output logic [BL_W-1:0]     pulse_block,
   output logic [BLOFF_W-1:0]  pulse_block_off,
   output logic                block,
   output logic                pump,
   output logic                cycle_start,
   output logic [SWEEP_W-1:0]  sweep_idx
);
   state_t     state;
   pulse_cfg_t cfg_in, pend_cfg, live;
   logic       pend, boundary, go, apply;

   assign cfg_in = '{per: cfg_per, p1wid: cfg_p1wid, del: cfg_del, p2wid: cfg_p2wid,
                     cp: cfg_cp, p_bl: cfg_p_bl, p_bl_off: cfg_p_bl_off, bl: cfg_bl, pu: cfg_pu};
   assign go     = (state == IDLE) && pend;
   assign apply  = go || (boundary && pend);

   period_timer #(.CNT_W(CNT_W), .MIN_PERIOD(MIN_PERIOD[CNT_W-1:0])) u_timer (
      .clk_pll    (clk_pll),
      .resetn     (resetn),
      .run        (state == RUN),
      .restart    (go),
      .period     (live.per[CNT_W-1:0]),
      .boundary   (boundary),
      .cycle_start(cycle_start)
   );

   // A strobe coinciding with an apply edge refills pending rather than being applied.
   always_ff @(posedge clk_pll) begin
      if (!resetn) begin
         state    <= IDLE;
         pend     <= 1'b0;
         pend_cfg <= '0;
         live     <= '0;
      end else begin
         if (cfg_stb) begin
            pend     <= 1'b1;
            pend_cfg <= cfg_in;
         end else if (apply) begin
            pend <= 1'b0;
         end
         if (apply) begin
            live  <= pend_cfg;
            state <= RUN;
         end
      end
   end

   assign cfg_busy        = pend;
   assign period          = live.per;
   assign p1width         = live.p1wid;
   assign p2width         = live.p2wid;
   assign cpmg            = live.cp;
   assign pulse_block     = live.p_bl;
   assign pulse_block_off = live.p_bl_off;
   assign block           = live.bl;
   assign pump            = live.pu;

`ifdef PULSE_DELAY_SWEEP_EN
   sweep_cfg_t         pend_sw, live_sw;
   logic [TIME_W-1:0]  delay_r;
   logic [SWEEP_W-1:0] idx, avg_cnt, avg_last;
   logic               adv, last;

   assign avg_last = (live_sw.avg == '0) ? '0 : live_sw.avg - 1'b1;
   assign adv      = boundary && (avg_cnt == avg_last) && (live_sw.n > 16'd1);
   assign last     = (idx == live_sw.n - 1'b1);

   // Delay tracks base + idx*inc incrementally, snapping back to base on wrap.
   always_ff @(posedge clk_pll) begin
      if (!resetn) begin
         pend_sw <= '0;
         live_sw <= '0;
         delay_r <= '0;
         idx     <= '0;
         avg_cnt <= '0;
      end else begin
         if (cfg_stb)
            pend_sw <= '{inc: sweep_step, n: sweep_n, avg: sweep_avg};
         if (apply) begin
            live_sw <= pend_sw;
            delay_r <= pend_cfg.del;
            idx     <= '0;
            avg_cnt <= '0;
         end else if (boundary) begin
            avg_cnt <= (avg_cnt == avg_last) ? '0 : avg_cnt + 1'b1;
            if (adv) begin
               idx     <= last ? '0 : idx + 1'b1;
               delay_r <= last ? live.del : delay_r + live_sw.inc;
            end
         end
      end
   end

   assign delay     = delay_r;
   assign sweep_idx = idx;
`else
   logic unused_sweep;
   assign unused_sweep = ^{sweep_step, sweep_n, sweep_avg};
   assign delay        = live.del;
   assign sweep_idx    = '0;
`endif
endmodule
